// File: rtl/cfg_pkg.sv
// ---------------------------------------------------------------------------
// cfg_pkg
//   Shared definitions for the Si5340 I2C responder: default device address,
//   read/write direction bit, FSM state type and encodings, and a 3-input
//   majority helper used by the optional input glitch filter.
// ---------------------------------------------------------------------------
package cfg_pkg;

    localparam logic [6:0] SLAVE_ADDR_DEFAULT = 7'h74;

    // Direction bit carried in the LSB of the device address byte.
    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } r_w_e;

    // Responder FSM state type; encodings kept as plain constants so the
    // state register stays a bare vector for existing debug tooling.
    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE     = 4'd0;
    localparam state_t ST_DEV_ADDR = 4'd1;
    localparam state_t ST_ACK_OUT  = 4'd2;
    localparam state_t ST_PTR_HI   = 4'd3;
    localparam state_t ST_PTR_LO   = 4'd4;
    localparam state_t ST_WDATA    = 4'd5;
    localparam state_t ST_TX_BYTE  = 4'd6;
    localparam state_t ST_ACK_IN   = 4'd7;
    localparam state_t ST_IGNORE   = 4'd8;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/i2c_bus_sampler.sv
// ---------------------------------------------------------------------------
// i2c_bus_sampler
//   Brings the raw SCL/SDA pad levels into the clk_i domain and turns them
//   into single-cycle bus event strobes.
//
//   Optional feature macro: SI5340_RESP_GLITCH_FILTER_EN
//     defined   -> 3-sample majority filter after the synchronizer; pulses
//                  shorter than 2 clk are rejected, edges arrive 2 clk later.
//     undefined -> synchronizer only.
//
// Ports
//   clk_i, arstn_i   system clock, async active-low reset
//   scl_raw          SCL pad level (asynchronous)
//   sda_raw          SDA pad level (asynchronous)
//   scl_rise         1-clk strobe, conditioned SCL went 0->1
//   scl_fall         1-clk strobe, conditioned SCL went 1->0
//   start_det        1-clk strobe, SDA 1->0 while SCL held high
//   stop_det         1-clk strobe, SDA 0->1 while SCL held high
//   sda_level        conditioned SDA level
// ---------------------------------------------------------------------------
module i2c_bus_sampler
    import cfg_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic arstn_i,
    input  logic scl_raw,
    input  logic sda_raw,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_level
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_lvl;
    logic                   sda_lvl;
    logic                   scl_q;
    logic                   sda_q;

    // Synchronizers reset to the idle-bus level (both lines high) so that
    // leaving reset never fabricates a START or STOP.
    // NOTE: sequential state is always updated with non-blocking assignments
    // so every flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_raw};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_raw};
        end
    end

`ifdef SI5340_RESP_GLITCH_FILTER_EN
    logic [1:0] scl_hist;
    logic [1:0] sda_hist;

    // Majority over the current and two previous synced samples, registered.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_lvl  <= 1'b1;
            sda_lvl  <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[SYNC_STAGES-1]};
            sda_hist <= {sda_hist[0], sda_sync[SYNC_STAGES-1]};
            scl_lvl  <= majority3(scl_sync[SYNC_STAGES-1], scl_hist[0], scl_hist[1]);
            sda_lvl  <= majority3(sda_sync[SYNC_STAGES-1], sda_hist[0], sda_hist[1]);
        end
    end
`else
    assign scl_lvl = scl_sync[SYNC_STAGES-1];
    assign sda_lvl = sda_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_lvl;
            sda_q <= sda_lvl;
        end
    end

    assign scl_rise  = scl_lvl & ~scl_q;
    assign scl_fall  = ~scl_lvl & scl_q;
    // SCL must be high in both samples, which also makes these strobes
    // mutually exclusive with the SCL edge strobes.
    assign start_det = scl_lvl & scl_q & sda_q & ~sda_lvl;
    assign stop_det  = scl_lvl & scl_q & ~sda_q & sda_lvl;
    assign sda_level = sda_lvl;

endmodule

// File: rtl/si5340_i2c_responder.sv
// ---------------------------------------------------------------------------
// si5340_i2c_responder
//   I2C target emulating the Si5340 register interface: 7-bit device address,
//   16-bit register pointer sent MSB first, 8-bit registers, pointer
//   auto-increment on both write and read. SCL/SDA are oversampled on clk_i;
//   only SDA is driven, open-drain style (sda_pad_o is constant 0 and
//   sda_padoen_o=0 pulls the line low). No clock stretching.
//
//   Optional feature macro: SI5340_RESP_GLITCH_FILTER_EN (see i2c_bus_sampler).
//
// Ports
//   clk_i, arstn_i     system clock (>= 16x SCL), async active-low reset
//   scl_pad_i          SCL line input
//   sda_pad_i          SDA line input
//   sda_pad_o          SDA output value, constant 0
//   sda_padoen_o       SDA output enable, active low
//   wr_valid_o         1-clk pulse per committed register write
//   wr_addr_o          pointer of the committed write
//   wr_data_o          data of the committed write
//   busy_o             high from address match until STOP
//   dbg_addr_i         backdoor register index
//   dbg_data_o         register file contents at dbg_addr_i, combinational
// ---------------------------------------------------------------------------
module si5340_i2c_responder
    import cfg_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = SLAVE_ADDR_DEFAULT,
    parameter int         ADDR_WIDTH  = 16,
    parameter int         DATA_WIDTH  = 8,
    parameter int         REG_DEPTH   = 256,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                         clk_i,
    input  logic                         arstn_i,
    input  logic                         scl_pad_i,
    input  logic                         sda_pad_i,
    output logic                         sda_pad_o,
    output logic                         sda_padoen_o,
    output logic                         wr_valid_o,
    output logic [ADDR_WIDTH-1:0]        wr_addr_o,
    output logic [DATA_WIDTH-1:0]        wr_data_o,
    output logic                         busy_o,
    input  logic [$clog2(REG_DEPTH)-1:0] dbg_addr_i,
    output logic [DATA_WIDTH-1:0]        dbg_data_o
);

    localparam int IDX_W = $clog2(REG_DEPTH);

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic sda_level;

    i2c_bus_sampler #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .clk_i     (clk_i),
        .arstn_i   (arstn_i),
        .scl_raw   (scl_pad_i),
        .sda_raw   (sda_pad_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_level (sda_level)
    );

    state_t                         state;
    state_t                         ack_next;     // state to enter when ACK_OUT ends
    logic                           ack_pending;  // byte accepted, ACK starts on next SCL fall
    logic [2:0]                     bit_cnt;
    logic [DATA_WIDTH-2:0]          rx_sh;
    logic [DATA_WIDTH-1:0]          tx_sh;
    logic [ADDR_WIDTH-1:0]          ptr;
    logic [ADDR_WIDTH-DATA_WIDTH-1:0] ptr_hi;
    logic                           master_ack;
    logic                           sda_oen;

    logic [DATA_WIDTH-1:0] mem [REG_DEPTH];
    logic [DATA_WIDTH-1:0] rx_byte;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  byte_end;
    logic                  mem_we;
    r_w_e                  dir;

    // Complete byte as it stands on the 8th SCL rise (current bit included).
    assign rx_byte   = {rx_sh, sda_level};
    assign dir       = r_w_e'(rx_byte[0]);
    assign byte_end  = scl_rise && (bit_cnt == 3'd7);
    assign mem_we    = byte_end && (state == ST_WDATA) && !start_det && !stop_det;
    assign mem_rdata = mem[ptr[IDX_W-1:0]];

    // NOTE: the register file carries no reset; its contents are whatever the
    // bus last wrote, which keeps it mappable onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[ptr[IDX_W-1:0]] <= rx_byte;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state       <= ST_IDLE;
            ack_next    <= ST_IDLE;
            ack_pending <= 1'b0;
            bit_cnt     <= 3'd0;
            rx_sh       <= '0;
            tx_sh       <= '0;
            ptr         <= '0;
            ptr_hi      <= '0;
            master_ack  <= 1'b0;
            sda_oen     <= 1'b1;
            busy_o      <= 1'b0;
            wr_valid_o  <= 1'b0;
            wr_addr_o   <= '0;
            wr_data_o   <= '0;
        end else begin
            wr_valid_o <= 1'b0;
            if (stop_det) begin
                state       <= ST_IDLE;
                ack_pending <= 1'b0;
                sda_oen     <= 1'b1;
                busy_o      <= 1'b0;
            end else if (start_det) begin
                // Repeated START keeps busy_o; the address phase re-decides it.
                state       <= ST_DEV_ADDR;
                ack_pending <= 1'b0;
                bit_cnt     <= 3'd0;
                sda_oen     <= 1'b1;
            end else begin
                case (state)
                    ST_DEV_ADDR, ST_PTR_HI, ST_PTR_LO, ST_WDATA: begin
                        if (scl_rise) begin
                            rx_sh   <= rx_byte[DATA_WIDTH-2:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (byte_end) begin
                                ack_pending <= 1'b1;
                                if (state == ST_DEV_ADDR) begin
                                    if (rx_byte[DATA_WIDTH-1:1] == SLAVE_ADDR) begin
                                        busy_o   <= 1'b1;
                                        ack_next <= (dir == READ) ? ST_TX_BYTE : ST_PTR_HI;
                                    end else begin
                                        // Not for us: stay silent until the next START/STOP.
                                        state       <= ST_IGNORE;
                                        busy_o      <= 1'b0;
                                        ack_pending <= 1'b0;
                                    end
                                end else if (state == ST_PTR_HI) begin
                                    ptr_hi   <= rx_byte;
                                    ack_next <= ST_PTR_LO;
                                end else if (state == ST_PTR_LO) begin
                                    // Pointer only changes once both bytes have arrived.
                                    ptr      <= {ptr_hi, rx_byte};
                                    ack_next <= ST_WDATA;
                                end else begin
                                    wr_valid_o <= 1'b1;
                                    wr_addr_o  <= ptr;
                                    wr_data_o  <= rx_byte;
                                    ptr        <= ptr + ADDR_WIDTH'(1);
                                    ack_next   <= ST_WDATA;
                                end
                            end
                        end else if (scl_fall && ack_pending) begin
                            state       <= ST_ACK_OUT;
                            ack_pending <= 1'b0;
                            sda_oen     <= 1'b0;
                        end
                    end

                    ST_ACK_OUT: begin
                        if (scl_fall) begin
                            state   <= ack_next;
                            bit_cnt <= 3'd0;
                            if (ack_next == ST_TX_BYTE) begin
                                // First read byte: present its MSB right away.
                                tx_sh   <= mem_rdata;
                                sda_oen <= mem_rdata[DATA_WIDTH-1];
                                ptr     <= ptr + ADDR_WIDTH'(1);
                            end else begin
                                sda_oen <= 1'b1;
                            end
                        end
                    end

                    ST_TX_BYTE: begin
                        // bit_cnt counts bits the master has clocked; it wraps
                        // to 0 after the 8th rise, which marks the byte end.
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 3'd0) begin
                                state   <= ST_ACK_IN;
                                sda_oen <= 1'b1;
                            end else begin
                                tx_sh   <= tx_sh << 1;
                                sda_oen <= tx_sh[DATA_WIDTH-2];
                            end
                        end
                    end

                    ST_ACK_IN: begin
                        if (scl_rise) begin
                            master_ack <= ~sda_level;
                        end else if (scl_fall) begin
                            if (master_ack) begin
                                state   <= ST_TX_BYTE;
                                bit_cnt <= 3'd0;
                                tx_sh   <= mem_rdata;
                                sda_oen <= mem_rdata[DATA_WIDTH-1];
                                ptr     <= ptr + ADDR_WIDTH'(1);
                            end else begin
                                state   <= ST_IGNORE;
                                sda_oen <= 1'b1;
                            end
                        end
                    end

                    ST_IDLE, ST_IGNORE: begin
                        sda_oen <= 1'b1;
                    end

                    default: begin
                        state   <= ST_IDLE;
                        sda_oen <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign sda_pad_o    = 1'b0;
    assign sda_padoen_o = sda_oen;
    assign dbg_data_o   = mem[dbg_addr_i];

endmodule

// File: tb/tb_si5340_i2c_responder.sv
// ---------------------------------------------------------------------------
// tb_si5340_i2c_responder
//   Bit-banged I2C master driving the responder over an open-drain SDA model.
//   Expected ACK bits, read bytes and register-write strobes are queued as
//   stimulus is issued; monitor processes pop and compare as the DUT responds.
// ---------------------------------------------------------------------------
module tb_si5340_i2c_responder;

    localparam int Q = 100;   // quarter SCL period = 10 clk

    logic        clk    = 1'b0;
    logic        arstn  = 1'b0;
    logic        m_scl  = 1'b1;
    logic        m_sda  = 1'b1;
    logic        sda_line;
    logic        sda_pad_o;
    logic        sda_padoen_o;
    logic        wr_valid_o;
    logic [15:0] wr_addr_o;
    logic [7:0]  wr_data_o;
    logic        busy_o;
    logic [7:0]  dbg_addr = 8'h00;
    logic [7:0]  dbg_data_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    exp_t       exp_q[$];
    logic [7:0] obs_q[$];
    wr_t        exp_wr_q[$];

    logic watch_drive = 1'b0;
    int   drive_seen  = 0;

    always #5 clk = ~clk;

    // Wired-AND bus: either side can pull low.
    assign sda_line = m_sda & (sda_padoen_o | sda_pad_o);

    si5340_i2c_responder dut (
        .clk_i        (clk),
        .arstn_i      (arstn),
        .scl_pad_i    (m_scl),
        .sda_pad_i    (sda_line),
        .sda_pad_o    (sda_pad_o),
        .sda_padoen_o (sda_padoen_o),
        .wr_valid_o   (wr_valid_o),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .busy_o       (busy_o),
        .dbg_addr_i   (dbg_addr),
        .dbg_data_o   (dbg_data_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bus-response scoreboard: ACK bits and read bytes.
    initial begin : mon_bus
        logic [7:0] o;
        exp_t       e;
        forever begin
            @(negedge clk);
            while (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bus_item: got %0h expected none", o);
                end else begin
                    e = exp_q.pop_front();
                    check(e.name, {24'd0, o}, {24'd0, e.val});
                end
            end
        end
    end

    // Register-write scoreboard.
    initial begin : mon_wr
        wr_t w;
        forever begin
            @(negedge clk);
            if (wr_valid_o === 1'b1) begin
                if (exp_wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got %04h/%02h expected none", wr_addr_o, wr_data_o);
                end else begin
                    w = exp_wr_q.pop_front();
                    check("wr_addr", {16'd0, wr_addr_o}, {16'd0, w.addr});
                    check("wr_data", {24'd0, wr_data_o}, {24'd0, w.data});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (watch_drive && sda_padoen_o !== 1'b1) drive_seen++;
    end

    initial begin : watchdog
        #(Q * 24000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- master primitives ----------------
    task automatic bit_out(input logic b);
        m_sda = b;
        #Q; m_scl = 1'b1;
        #(2 * Q); m_scl = 1'b0;
        #Q;
    endtask

    task automatic bit_in(output logic b);
        m_sda = 1'b1;
        #Q; m_scl = 1'b1;
        #Q; b = sda_line;
        #Q; m_scl = 1'b0;
        #Q;
    endtask

    // Works from idle and as a repeated START from SCL low.
    task automatic i2c_start();
        m_sda = 1'b1;
        #Q; m_scl = 1'b1;
        #Q; m_sda = 1'b0;
        #Q; m_scl = 1'b0;
        #Q;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0;
        #Q; m_scl = 1'b1;
        #Q; m_sda = 1'b1;
        #(2 * Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input logic exp_ack_bit);
        logic a;
        exp_t e;
        e.name = $sformatf("ack_%02h", b);
        e.val  = {7'd0, exp_ack_bit};
        exp_q.push_back(e);
        for (int i = 7; i >= 0; i--) bit_out(b[i]);
        bit_in(a);
        obs_q.push_back({7'd0, a});
    endtask

    task automatic write_data(input logic [7:0] b, input logic [15:0] exp_addr);
        wr_t w;
        w.addr = exp_addr;
        w.data = b;
        exp_wr_q.push_back(w);
        write_byte(b, 1'b0);
    endtask

    task automatic read_byte(input logic [7:0] exp_val, input logic nack);
        logic [7:0] r;
        logic       b;
        exp_t       e;
        e.name = $sformatf("rd_%02h", exp_val);
        e.val  = exp_val;
        exp_q.push_back(e);
        for (int i = 7; i >= 0; i--) begin
            bit_in(b);
            r[i] = b;
        end
        obs_q.push_back(r);
        bit_out(nack);
    endtask

    task automatic dbg_check(input string name, input logic [7:0] idx, input logic [7:0] exp);
        dbg_addr = idx;
        #1;
        check(name, {24'd0, dbg_data_o}, {24'd0, exp});
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_oen"},    {31'd0, sda_padoen_o}, 32'd1);
        check({tag, "_pad_o"},  {31'd0, sda_pad_o},    32'd0);
        check({tag, "_wr_vld"}, {31'd0, wr_valid_o},   32'd0);
        check({tag, "_wr_adr"}, {16'd0, wr_addr_o},    32'd0);
        check({tag, "_wr_dat"}, {24'd0, wr_data_o},    32'd0);
        check({tag, "_busy"},   {31'd0, busy_o},       32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        #23;
        check_reset_state("rst");
        #20 arstn = 1'b1;
        #(4 * Q);

        // 1: single write 74/W 00 2B A5
        i2c_start();
        write_byte(8'hE8, 1'b0);
        check("t1_busy", {31'd0, busy_o}, 32'd1);
        write_byte(8'h00, 1'b0);
        write_byte(8'h2B, 1'b0);
        write_data(8'hA5, 16'h002B);
        i2c_stop();
        check("t1_busy_stop", {31'd0, busy_o}, 32'd0);
        dbg_check("t1_mem2b", 8'h2B, 8'hA5);

        // Seed mem[13] so the pointer-less read below reveals the pointer.
        i2c_start();
        write_byte(8'hE8, 1'b0);
        write_byte(8'h00, 1'b0);
        write_byte(8'h13, 1'b0);
        write_data(8'h77, 16'h0013);
        i2c_stop();

        // 2: burst write at 0010
        i2c_start();
        write_byte(8'hE8, 1'b0);
        write_byte(8'h00, 1'b0);
        write_byte(8'h10, 1'b0);
        write_data(8'h11, 16'h0010);
        write_data(8'h22, 16'h0011);
        write_data(8'h33, 16'h0012);
        i2c_stop();
        dbg_check("t2_mem10", 8'h10, 8'h11);
        dbg_check("t2_mem11", 8'h11, 8'h22);
        dbg_check("t2_mem12", 8'h12, 8'h33);

        // Read with no pointer phase: pointer left at 0013.
        i2c_start();
        write_byte(8'hE9, 1'b0);
        read_byte(8'h77, 1'b1);
        check("t2_rd_release", {31'd0, sda_padoen_o}, 32'd1);
        i2c_stop();

        // 3: pointer write then repeated-START read of three bytes
        i2c_start();
        write_byte(8'hE8, 1'b0);
        write_byte(8'h00, 1'b0);
        write_byte(8'h10, 1'b0);
        i2c_start();
        write_byte(8'hE9, 1'b0);
        read_byte(8'h11, 1'b0);
        read_byte(8'h22, 1'b0);
        read_byte(8'h33, 1'b1);
        check("t3_release", {31'd0, sda_padoen_o}, 32'd1);
        i2c_stop();

        // 4: wrong address 75/W is ignored
        i2c_start();
        watch_drive = 1'b1;
        write_byte(8'hEA, 1'b1);
        write_byte(8'h00, 1'b1);
        write_byte(8'h10, 1'b1);
        check("t4_busy", {31'd0, busy_o}, 32'd0);
        watch_drive = 1'b0;
        check("t4_no_drive", drive_seen, 32'd0);
        i2c_stop();
        check("t4_busy_stop", {31'd0, busy_o}, 32'd0);

        // 5: pointer wrap FFFF -> 0000
        i2c_start();
        write_byte(8'hE8, 1'b0);
        write_byte(8'hFF, 1'b0);
        write_byte(8'hFF, 1'b0);
        write_data(8'h5A, 16'hFFFF);
        write_data(8'h6B, 16'h0000);
        i2c_stop();
        dbg_check("t5_memff", 8'hFF, 8'h5A);
        dbg_check("t5_mem00", 8'h00, 8'h6B);

        // 6: reset while the responder is acknowledging its address
        i2c_start();
        for (int i = 7; i >= 0; i--) bit_out(8'hE8 >> i);
        m_sda = 1'b1;
        #20;
        check("t6_ack_drive", {31'd0, sda_padoen_o}, 32'd0);
        arstn = 1'b0;
        #1;
        check("t6_rst_release", {31'd0, sda_padoen_o}, 32'd1);
        #50;
        check_reset_state("t6");
        #3 arstn = 1'b1;
        #Q;  m_scl = 1'b1;
        #Q;  m_scl = 1'b0;
        #Q;
        i2c_stop();

        i2c_start();
        write_byte(8'hE8, 1'b0);
        write_byte(8'h00, 1'b0);
        write_byte(8'h2B, 1'b0);
        write_data(8'h5C, 16'h002B);
        i2c_stop();
        dbg_check("t6_mem2b", 8'h2B, 8'h5C);

        // Drain scoreboards.
        #(4 * Q);
        check("exp_bus_left", exp_q.size(), 32'd0);
        check("exp_wr_left",  exp_wr_q.size(), 32'd0);
        check("obs_bus_left", obs_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
